// File: rtl/uart_reg_responder.sv
// uart_reg_responder
//   Register-access responder on the user side of a UART controller. Received
//   bytes form a command stream: a read command returns the addressed register,
//   a write command is followed by one data byte and returns ACK. Illegal
//   addresses (reserved command bits set) return NAK. Exactly one response
//   byte is produced per completed command; a write whose data byte does not
//   arrive in time is aborted silently with a timeout pulse.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   rx_data      received byte, qualified by rx_valid
//   rx_valid     one-cycle strobe for rx_data
//   tx_byte      response byte, stable while tx_valid is high
//   tx_valid     response pending
//   tx_ready     transmit path can accept a byte
//   regs_out     flat register file, reg i at [i*DATA_BITS +: DATA_BITS]
//   timeout_err  one-cycle pulse: write aborted waiting for its data byte
//   overrun_err  one-cycle pulse: rx byte dropped while a response was pending
module uart_reg_responder #(
    parameter int                   DATA_BITS      = 8,
    parameter int                   ADDR_BITS      = 4,
    parameter int                   TIMEOUT_CYCLES = 1000000,
    parameter logic [DATA_BITS-1:0] ACK_BYTE       = 8'hA5,
    parameter logic [DATA_BITS-1:0] NAK_BYTE       = 8'h5A
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [DATA_BITS-1:0]                 rx_data,
    input  logic                                 rx_valid,
    output logic [DATA_BITS-1:0]                 tx_byte,
    output logic                                 tx_valid,
    input  logic                                 tx_ready,
    output logic [(2**ADDR_BITS)*DATA_BITS-1:0]  regs_out,
    output logic                                 timeout_err,
    output logic                                 overrun_err
);

    localparam int NUM_REGS   = 2 ** ADDR_BITS;
    // Timer only has to count up to TIMEOUT_CYCLES-1.
    localparam int TIMER_BITS = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TIMER_BITS-1:0] TIMER_LAST = TIMER_BITS'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_DATA = 2'd1,
        ST_RESP      = 2'd2
    } state_t;

    state_t                 state_r;
    state_t                 next_state_s;
    logic [DATA_BITS-1:0]   regs_r [NUM_REGS];
    logic [DATA_BITS-1:0]   cmd_r;
    logic [DATA_BITS-1:0]   next_cmd_s;
    logic [TIMER_BITS-1:0]  timer_r;
    logic [TIMER_BITS-1:0]  next_timer_s;
    logic [DATA_BITS-1:0]   tx_byte_r;
    logic [DATA_BITS-1:0]   next_tx_byte_s;
    logic                   tx_valid_r;
    logic                   next_tx_valid_s;
    logic                   timeout_err_r;
    logic                   next_timeout_s;
    logic                   overrun_err_r;
    logic                   next_overrun_s;
    logic                   wr_en_s;

    // A command addresses a real register only if every reserved bit between
    // the address field and the read/write bit is zero.
    function automatic logic addr_legal(input logic [DATA_BITS-1:0] cmd);
        logic [DATA_BITS-2:0] body;
        body = cmd[DATA_BITS-2:0];
        return ((body >> ADDR_BITS) == '0);
    endfunction

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state, response and error-pulse decode.
    always_comb begin
        next_state_s    = state_r;
        next_cmd_s      = cmd_r;
        next_timer_s    = timer_r;
        next_tx_byte_s  = tx_byte_r;
        next_tx_valid_s = tx_valid_r;
        next_timeout_s  = 1'b0;
        next_overrun_s  = 1'b0;
        wr_en_s         = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (rx_valid) begin
                    if (rx_data[DATA_BITS-1]) begin
                        next_cmd_s   = rx_data;
                        next_timer_s = '0;
                        next_state_s = ST_WAIT_DATA;
                    end else begin
                        next_state_s    = ST_RESP;
                        next_tx_valid_s = 1'b1;
                        if (addr_legal(rx_data)) begin
                            next_tx_byte_s = regs_r[rx_data[ADDR_BITS-1:0]];
                        end else begin
                            next_tx_byte_s = NAK_BYTE;
                        end
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WAIT_DATA: begin
                // A data byte on the final timer cycle still wins over the timeout.
                if (rx_valid) begin
                    next_state_s    = ST_RESP;
                    next_tx_valid_s = 1'b1;
                    if (addr_legal(cmd_r)) begin
                        wr_en_s        = 1'b1;
                        next_tx_byte_s = ACK_BYTE;
                    end else begin
                        next_tx_byte_s = NAK_BYTE;
                    end
                end else if (timer_r == TIMER_LAST) begin
                    next_state_s   = ST_IDLE;
                    next_timeout_s = 1'b1;
                    next_timer_s   = '0;
                end else begin
                    next_timer_s = timer_r + {{(TIMER_BITS-1){1'b0}}, 1'b1};
                end
            end
            ST_RESP: begin
                // Bytes arriving while a response is pending are dropped.
                next_overrun_s = rx_valid;
                if (tx_ready) begin
                    next_state_s    = ST_IDLE;
                    next_tx_valid_s = 1'b0;
                end else begin
                    next_tx_valid_s = 1'b1;
                end
            end
            default: begin
                next_state_s    = ST_IDLE;
                next_tx_valid_s = 1'b0;
            end
        endcase
    end

    // Datapath registers: latched command, timer, response and error pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmd_r         <= '0;
            timer_r       <= '0;
            tx_byte_r     <= '0;
            tx_valid_r    <= 1'b0;
            timeout_err_r <= 1'b0;
            overrun_err_r <= 1'b0;
        end else begin
            cmd_r         <= next_cmd_s;
            timer_r       <= next_timer_s;
            tx_byte_r     <= next_tx_byte_s;
            tx_valid_r    <= next_tx_valid_s;
            timeout_err_r <= next_timeout_s;
            overrun_err_r <= next_overrun_s;
        end
    end

    // Register file write port; the data byte lands in the latched address.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= '0;
            end
        end else if (wr_en_s) begin
            regs_r[cmd_r[ADDR_BITS-1:0]] <= rx_data;
        end else begin
            regs_r <= regs_r;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
        assign regs_out[g*DATA_BITS +: DATA_BITS] = regs_r[g];
    end

    assign tx_byte     = tx_byte_r;
    assign tx_valid    = tx_valid_r;
    assign timeout_err = timeout_err_r;
    assign overrun_err = overrun_err_r;

endmodule

// File: tb/tb_uart_reg_responder.sv
module tb_uart_reg_responder;

    logic         clk;
    logic         reset;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic [7:0]   tx_byte;
    logic         tx_valid;
    logic         tx_ready;
    logic [127:0] regs_out;
    logic         timeout_err;
    logic         overrun_err;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] exp_q [$];
    logic [7:0] model [16];

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] data;
        logic [7:0] resp;
    } vec_t;

    vec_t vecs [14];

    uart_reg_responder #(
        .DATA_BITS      (8),
        .ADDR_BITS      (4),
        .TIMEOUT_CYCLES (16),
        .ACK_BYTE       (8'hA5),
        .NAK_BYTE       (8'h5A)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_byte     (tx_byte),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .regs_out    (regs_out),
        .timeout_err (timeout_err),
        .overrun_err (overrun_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] model_flat();
        logic [127:0] f;
        for (int i = 0; i < 16; i++) f[i*8 +: 8] = model[i];
        return f;
    endfunction

    // Scoreboard: a transfer happens at the next rising edge, pop and compare.
    always @(negedge clk) begin
        if (reset && tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_response", {120'd0, tx_byte}, 128'd0);
            end else begin
                chk("response_byte", {120'd0, tx_byte}, {120'd0, exp_q.pop_front()});
            end
        end
    end

    // Sends one command (and its data byte for writes), checks latency and regs.
    task automatic apply(input vec_t v);
        rx_data  = v.cmd;
        rx_valid = 1'b1;
        if (v.cmd[7]) begin
            tick();
            rx_data = v.data;
        end
        exp_q.push_back(v.resp);
        tick();
        rx_valid = 1'b0;
        chk("tx_valid_latency", {127'd0, tx_valid}, 128'd1);
        if (v.cmd[7] && v.cmd[6:4] == 3'd0) model[v.cmd[3:0]] = v.data;
        chk("regs_out", regs_out, model_flat());
        tick();
        chk("tx_valid_after_transfer", {127'd0, tx_valid}, 128'd0);
    endtask

    initial begin
        int pulses;
        int first;
        int txs;
        int bad;
        vec_t v;

        vecs[0]  = '{8'h83, 8'h3C, 8'hA5};
        vecs[1]  = '{8'h03, 8'h00, 8'h3C};
        vecs[2]  = '{8'h13, 8'h00, 8'h5A};
        vecs[3]  = '{8'h93, 8'hFF, 8'h5A};
        vecs[4]  = '{8'h03, 8'h00, 8'h3C};
        vecs[5]  = '{8'h8F, 8'hC3, 8'hA5};
        vecs[6]  = '{8'h0F, 8'h00, 8'hC3};
        vecs[7]  = '{8'h00, 8'h00, 8'h00};
        vecs[8]  = '{8'hC0, 8'h11, 8'h5A};
        vecs[9]  = '{8'h80, 8'h7E, 8'hA5};
        vecs[10] = '{8'h00, 8'h00, 8'h7E};
        vecs[11] = '{8'h7F, 8'h00, 8'h5A};
        vecs[12] = '{8'h83, 8'h44, 8'hA5};
        vecs[13] = '{8'h03, 8'h00, 8'h44};

        for (int i = 0; i < 16; i++) model[i] = 8'h00;

        reset    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        #2;
        chk("reset_tx_valid", {127'd0, tx_valid}, 128'd0);
        chk("reset_tx_byte", {120'd0, tx_byte}, 128'd0);
        chk("reset_timeout_err", {127'd0, timeout_err}, 128'd0);
        chk("reset_overrun_err", {127'd0, overrun_err}, 128'd0);
        chk("reset_regs_out", regs_out, 128'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        for (int i = 0; i < 14; i++) apply(vecs[i]);

        // Write command followed by silence: one timeout pulse, no response.
        rx_data  = 8'h81;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        pulses = 0;
        first  = 0;
        txs    = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (timeout_err) begin
                pulses++;
                if (first == 0) first = k;
            end
            if (tx_valid) txs++;
        end
        chk("timeout_pulse_count", 128'(pulses), 128'd1);
        chk("timeout_pulse_cycle", 128'(first), 128'd16);
        chk("timeout_no_response", 128'(txs), 128'd0);
        v = '{8'h01, 8'h00, 8'h00};
        apply(v);

        // Data byte on the exact final timeout cycle is accepted.
        rx_data  = 8'h82;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        for (int k = 1; k <= 15; k++) tick();
        rx_data  = 8'h5D;
        rx_valid = 1'b1;
        exp_q.push_back(8'hA5);
        tick();
        rx_valid = 1'b0;
        model[2] = 8'h5D;
        chk("boundary_tx_valid", {127'd0, tx_valid}, 128'd1);
        chk("boundary_no_timeout", {127'd0, timeout_err}, 128'd0);
        chk("boundary_regs_out", regs_out, model_flat());
        tick();
        chk("boundary_no_timeout_late", {127'd0, timeout_err}, 128'd0);
        chk("boundary_tx_done", {127'd0, tx_valid}, 128'd0);

        // Backpressure with an overrun byte injected while the response waits.
        tx_ready = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b1;
        exp_q.push_back(8'h7E);
        tick();
        chk("bp_tx_valid", {127'd0, tx_valid}, 128'd1);
        chk("bp_tx_byte", {120'd0, tx_byte}, {120'd0, 8'h7E});
        bad    = 0;
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            rx_valid = (k == 0);
            rx_data  = 8'h05;
            tick();
            if (!(tx_valid && tx_byte == 8'h7E)) bad++;
            if (overrun_err) pulses++;
        end
        rx_valid = 1'b0;
        chk("bp_held_cycles_bad", 128'(bad), 128'd0);
        chk("bp_overrun_pulses", 128'(pulses), 128'd1);
        tx_ready = 1'b1;
        tick();
        chk("bp_released", {127'd0, tx_valid}, 128'd0);
        tick();
        chk("bp_single_transfer", {127'd0, tx_valid}, 128'd0);

        // Reset in the middle of a write.
        rx_data  = 8'h82;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        reset    = 1'b0;
        #1;
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        chk("midreset_regs_out", regs_out, 128'd0);
        chk("midreset_tx_valid", {127'd0, tx_valid}, 128'd0);
        chk("midreset_tx_byte", {120'd0, tx_byte}, 128'd0);
        chk("midreset_errs", {126'd0, timeout_err, overrun_err}, 128'd0);
        tick();
        reset = 1'b1;
        // 0x77 has bit7 clear: a read with reserved bits set, so NAK and no write.
        v = '{8'h77, 8'h00, 8'h5A};
        apply(v);
        chk("postreset_reg2", {120'd0, regs_out[23:16]}, 128'd0);

        chk("scoreboard_drained", 128'(exp_q.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
